// File: rtl/sign_zero_extend.sv
// sign_zero_extend: widens a decode-stage immediate by sign or zero extension.
// The combinational output feeds decode directly in the same cycle. A
// registered copy with a valid flag is kept for use across a stage boundary.
module sign_zero_extend #(
  parameter int DATA_ORIGINAL_SIZE = 16,
  parameter int DATA_EXTENDED_SIZE = 32
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [DATA_ORIGINAL_SIZE-1:0] i_value,
  input  logic                          i_is_signed,
  input  logic                          i_valid,
  output logic [DATA_EXTENDED_SIZE-1:0] o_extended_value,
  output logic [DATA_EXTENDED_SIZE-1:0] o_extended_value_q,
  output logic                          o_valid_q
);

  // Reject configurations that cannot be built while the design elaborates,
  // instead of silently truncating the immediate.
  generate
    if (DATA_ORIGINAL_SIZE < 1) begin : g_bad_original_size
      $error("sign_zero_extend: DATA_ORIGINAL_SIZE must be at least 1");
    end
    if (DATA_EXTENDED_SIZE < DATA_ORIGINAL_SIZE) begin : g_bad_extended_size
      $error("sign_zero_extend: DATA_EXTENDED_SIZE must be >= DATA_ORIGINAL_SIZE");
    end
  endgenerate

  // The fill bit is the input MSB when sign extending and zero otherwise.
  logic                          fill_bit;
  logic [DATA_EXTENDED_SIZE-1:0] extended;

  assign fill_bit = i_is_signed & i_value[DATA_ORIGINAL_SIZE-1];

  // Start from a vector made entirely of fill bits, then overlay the original
  // value on the low bits. This form also covers equal widths: the overlay
  // replaces every fill bit, so no zero-width replication is ever formed.
  always_comb begin
    extended                         = {DATA_EXTENDED_SIZE{fill_bit}};
    extended[DATA_ORIGINAL_SIZE-1:0] = i_value;
  end

  assign o_extended_value = extended;

  // Stage-boundary copy. A valid cycle loads the extended value. An idle cycle
  // keeps the last value and clears the flag. Reset clears both immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_extended_value_q <= '0;
      o_valid_q          <= 1'b0;
    end else begin
      o_valid_q <= i_valid;
      if (i_valid) begin
        o_extended_value_q <= extended;
      end
    end
  end

endmodule

// File: tb/tb_sign_zero_extend.sv
// Directed testbench for sign_zero_extend. It covers the default 16->32
// instance plus an 8->16 instance and a 16->16 equal-width instance.
module tb_sign_zero_extend;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic        is_signed;
  logic        valid;
  logic [31:0] ext;
  logic [31:0] ext_q;
  logic        v_q;

  logic [7:0]  value8;
  logic [15:0] ext8;
  logic [15:0] ext8_q;
  logic        v8_q;

  logic [15:0] ext_eq;
  logic [15:0] ext_eq_q;
  logic        v_eq_q;

  int checks;
  int errors;

  sign_zero_extend #(
    .DATA_ORIGINAL_SIZE(16),
    .DATA_EXTENDED_SIZE(32)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_value           (value),
    .i_is_signed       (is_signed),
    .i_valid           (valid),
    .o_extended_value  (ext),
    .o_extended_value_q(ext_q),
    .o_valid_q         (v_q)
  );

  sign_zero_extend #(
    .DATA_ORIGINAL_SIZE(8),
    .DATA_EXTENDED_SIZE(16)
  ) dut_8_16 (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_value           (value8),
    .i_is_signed       (is_signed),
    .i_valid           (valid),
    .o_extended_value  (ext8),
    .o_extended_value_q(ext8_q),
    .o_valid_q         (v8_q)
  );

  sign_zero_extend #(
    .DATA_ORIGINAL_SIZE(16),
    .DATA_EXTENDED_SIZE(16)
  ) dut_eq (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_value           (value),
    .i_is_signed       (is_signed),
    .i_valid           (valid),
    .o_extended_value  (ext_eq),
    .o_extended_value_q(ext_eq_q),
    .o_valid_q         (v_eq_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset is asserted from time zero. The registered outputs must already be
  // clear before any clock edge has occurred.
  task automatic test_reset;
    rst_n = 1'b0;
    valid = 1'b0;
    is_signed = 1'b0;
    value = 16'h0000;
    value8 = 8'h00;
    #1;
    checks++;
    if (ext_q !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_ext_q got %h expected %h", ext_q, 32'h0);
    end
    checks++;
    if (v_q !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid_q got %b expected %b", v_q, 1'b0);
    end
  endtask

  // These vectors run while reset is still low, so they also show that the
  // combinational path keeps tracking its inputs during reset.
  task automatic test_comb_positive_and_zero;
    value = 16'h000A; is_signed = 1'b1; #1;
    checks++;
    if (ext !== 32'h0000000A) begin
      errors++;
      $display("[TB] FAIL pos_signed got %h expected %h", ext, 32'h0000000A);
    end
    is_signed = 1'b0; #1;
    checks++;
    if (ext !== 32'h0000000A) begin
      errors++;
      $display("[TB] FAIL pos_unsigned got %h expected %h", ext, 32'h0000000A);
    end
    value = 16'h0000; is_signed = 1'b0; #1;
    checks++;
    if (ext !== 32'h00000000) begin
      errors++;
      $display("[TB] FAIL zero_unsigned got %h expected %h", ext, 32'h00000000);
    end
  endtask

  // Negative inputs with sign extension select must fill the upper bits with ones.
  task automatic test_comb_signed_negative;
    value = 16'hFFFA; is_signed = 1'b1; #1;
    checks++;
    if (ext !== 32'hFFFFFFFA) begin
      errors++;
      $display("[TB] FAIL neg_fffa got %h expected %h", ext, 32'hFFFFFFFA);
    end
    value = 16'h8000; #1;
    checks++;
    if (ext !== 32'hFFFF8000) begin
      errors++;
      $display("[TB] FAIL neg_8000 got %h expected %h", ext, 32'hFFFF8000);
    end
  endtask

  // 0x7FFF is the largest positive value. Both modes must give the same result.
  task automatic test_comb_max_positive;
    value = 16'h7FFF; is_signed = 1'b1; #1;
    checks++;
    if (ext !== 32'h00007FFF) begin
      errors++;
      $display("[TB] FAIL max_pos_signed got %h expected %h", ext, 32'h00007FFF);
    end
    is_signed = 1'b0; #1;
    checks++;
    if (ext !== 32'h00007FFF) begin
      errors++;
      $display("[TB] FAIL max_pos_unsigned got %h expected %h", ext, 32'h00007FFF);
    end
  endtask

  // A negative bit pattern with zero extension selected must fill the upper bits with zeros.
  task automatic test_zero_extend_negative;
    value = 16'hFFFA; is_signed = 1'b0; #1;
    checks++;
    if (ext !== 32'h0000FFFA) begin
      errors++;
      $display("[TB] FAIL zext_fffa got %h expected %h", ext, 32'h0000FFFA);
    end
    checks++;
    if (ext_q !== 32'h0 || v_q !== 1'b0) begin
      errors++;
      $display("[TB] FAIL in_reset_q got %h/%b expected %h/%b", ext_q, v_q, 32'h0, 1'b0);
    end
  endtask

  // Release reset, then capture 0x8000 signed. The result must appear one edge later.
  task automatic test_registered;
    @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b1; value = 16'h8000; is_signed = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ext_q !== 32'hFFFF8000) begin
      errors++;
      $display("[TB] FAIL reg_capture got %h expected %h", ext_q, 32'hFFFF8000);
    end
    checks++;
    if (v_q !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reg_valid got %b expected %b", v_q, 1'b1);
    end
  endtask

  // With valid dropped, the flag clears and the value is held even though the input changes.
  task automatic test_hold;
    @(negedge clk);
    valid = 1'b0; value = 16'h000A; is_signed = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (v_q !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_valid got %b expected %b", v_q, 1'b0);
    end
    checks++;
    if (ext_q !== 32'hFFFF8000) begin
      errors++;
      $display("[TB] FAIL hold_value got %h expected %h", ext_q, 32'hFFFF8000);
    end
  endtask

  // A new value is accepted on every consecutive cycle.
  task automatic test_back_to_back;
    @(negedge clk);
    valid = 1'b1; value = 16'h7FFF; is_signed = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ext_q !== 32'h00007FFF || v_q !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_0 got %h/%b expected %h/%b", ext_q, v_q, 32'h00007FFF, 1'b1);
    end
    @(negedge clk);
    value = 16'hFFFA; is_signed = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ext_q !== 32'h0000FFFA || v_q !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_1 got %h/%b expected %h/%b", ext_q, v_q, 32'h0000FFFA, 1'b1);
    end
    @(negedge clk);
    is_signed = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ext_q !== 32'hFFFFFFFA || v_q !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_2 got %h/%b expected %h/%b", ext_q, v_q, 32'hFFFFFFFA, 1'b1);
    end
  endtask

  // Reset asserted mid-cycle clears the registers at once. A valid input held
  // during reset is discarded. After release, the next edge captures again.
  task automatic test_async_reset_mid_cycle;
    @(negedge clk);
    valid = 1'b1; value = 16'h1234; is_signed = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ext_q !== 32'h00001234 || v_q !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset got %h/%b expected %h/%b", ext_q, v_q, 32'h00001234, 1'b1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ext_q !== 32'h0 || v_q !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset got %h/%b expected %h/%b", ext_q, v_q, 32'h0, 1'b0);
    end
    checks++;
    if (ext !== 32'h00001234) begin
      errors++;
      $display("[TB] FAIL comb_in_reset got %h expected %h", ext, 32'h00001234);
    end
    @(posedge clk); #1;
    checks++;
    if (ext_q !== 32'h0 || v_q !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_discard got %h/%b expected %h/%b", ext_q, v_q, 32'h0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    value = 16'hFFFA; is_signed = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ext_q !== 32'hFFFFFFFA || v_q !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_release got %h/%b expected %h/%b", ext_q, v_q, 32'hFFFFFFFA, 1'b1);
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Check the 8-bit input to 16-bit output instance.
  task automatic test_variant_8_16;
    value8 = 8'h80; is_signed = 1'b1; #1;
    checks++;
    if (ext8 !== 16'hFF80) begin
      errors++;
      $display("[TB] FAIL v8_signed got %h expected %h", ext8, 16'hFF80);
    end
    is_signed = 1'b0; #1;
    checks++;
    if (ext8 !== 16'h0080) begin
      errors++;
      $display("[TB] FAIL v8_unsigned got %h expected %h", ext8, 16'h0080);
    end
    value8 = 8'h7F; is_signed = 1'b1; #1;
    checks++;
    if (ext8 !== 16'h007F) begin
      errors++;
      $display("[TB] FAIL v8_maxpos got %h expected %h", ext8, 16'h007F);
    end
  endtask

  // Equal widths pass the value through unchanged in either mode.
  task automatic test_equal_width;
    value = 16'hFFFA; is_signed = 1'b1; #1;
    checks++;
    if (ext_eq !== 16'hFFFA) begin
      errors++;
      $display("[TB] FAIL eq_signed got %h expected %h", ext_eq, 16'hFFFA);
    end
    is_signed = 1'b0; #1;
    checks++;
    if (ext_eq !== 16'hFFFA) begin
      errors++;
      $display("[TB] FAIL eq_unsigned got %h expected %h", ext_eq, 16'hFFFA);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_comb_positive_and_zero();
    test_comb_signed_negative();
    test_comb_max_positive();
    test_zero_extend_negative();
    test_registered();
    test_hold();
    test_back_to_back();
    test_async_reset_mid_cycle();
    test_variant_8_16();
    test_equal_width();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
